// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC timestamp readout path: widths, sync byte and
// the drain controller state encoding.
package tdc_pkg;

   localparam int          TS_W     = 48;
   localparam logic [7:0]  TDC_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LATCH = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/tdc_fifo_drain_tx_if.sv
// FIFO read port plus valid/ready byte stream between the drain controller
// (master) and its surroundings (slave: timestamp FIFO and UART transmitter).
interface tdc_fifo_drain_tx_if #(
   parameter int DATA_W = 48
);
   logic              buf_empty;
   logic              rd_en;
   logic [DATA_W-1:0] buf_out;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      input  buf_empty, buf_out, tx_ready,
      output rd_en, tx_data, tx_valid
   );

   modport slave (
      output buf_empty, buf_out, tx_ready,
      input  rd_en, tx_data, tx_valid
   );
endinterface

// File: rtl/tdc_byte_shifter.sv
// Holds one FIFO word and presents it a byte at a time, MSB first; advances one
// byte per accepted handshake and flags when the final byte is on the output.
module tdc_byte_shifter #(
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   input  logic              shift,
   output logic [7:0]        byte_out,
   output logic              last_byte
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = $clog2(NBYTES + 1);

   logic [DATA_W-1:0] sreg;
   logic [IDX_W-1:0]  cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= din;
         cnt  <= '0;
      end else if (shift) begin
         sreg <= sreg << 8;
         cnt  <= cnt + 1'b1;
      end
   end

   assign byte_out  = sreg[DATA_W-1 -: 8];
   assign last_byte = (cnt == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/tdc_fifo_drain_tx.sv
// Pops timestamp words from the TDC FIFO and frames each as an optional sync
// byte followed by the data bytes (MSB first) towards the UART transmitter.
//
// state | meaning
// IDLE  | waiting for a non-empty FIFO
// POP   | rd_en high; FIFO presents the word at the end of this cycle
// LATCH | word captured into the shifter, byte index cleared
// SEND  | bytes presented with tx_valid until the last one is accepted
// DONE  | frame complete, frame counter advanced
module tdc_fifo_drain_tx
   import tdc_pkg::*;
#(
   parameter int         DATA_W      = TS_W,
   parameter logic [7:0] HEADER      = TDC_SYNC,
   parameter bit         SEND_HEADER = 1'b1,
   parameter int         CNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   tdc_fifo_drain_tx_if.master bus,
   output logic                busy,
   output logic [CNT_W-1:0]    frame_cnt
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = $clog2(NBYTES + 1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic             rd_en_q;
   logic             xfer;
   logic             hdr_phase;
   logic             sh_load;
   logic             sh_shift;
   logic             sh_last;
   logic [7:0]       sh_byte;

   tdc_byte_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .din       (bus.buf_out),
      .shift     (sh_shift),
      .byte_out  (sh_byte),
      .last_byte (sh_last)
   );

   assign hdr_phase = SEND_HEADER && (idx == '0);
   assign xfer      = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         rd_en_q   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         rd_en_q <= (state_nxt == POP);
         if (state == DONE) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.buf_empty) begin
               state_nxt = POP;
            end
         end
         POP: begin
            state_nxt = LATCH;
         end
         LATCH: begin
            sh_load   = 1'b1;
            idx_nxt   = '0;
            state_nxt = SEND;
         end
         SEND: begin
            if (xfer) begin
               idx_nxt  = idx + 1'b1;
               // the header byte comes from the constant, so it does not consume shifter data
               sh_shift = !hdr_phase;
               if (!hdr_phase && sh_last) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.rd_en    = rd_en_q;
   assign bus.tx_valid = (state == SEND);
   assign bus.tx_data  = bus.tx_valid ? (hdr_phase ? HEADER : sh_byte) : 8'h00;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_tdc_fifo_drain_tx.sv
// Directed-plus-random bench for tdc_fifo_drain_tx: a word-level FIFO model feeds
// two instances (default and headerless 2-bit counter) and byte streams are
// compared with frames expanded from the words.
module tb_tdc_fifo_drain_tx;
   import tdc_pkg::*;

   localparam int DW = 48;
   localparam int NB = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tdc_fifo_drain_tx_if #(.DATA_W(DW)) bus_a ();
   tdc_fifo_drain_tx_if #(.DATA_W(DW)) bus_b ();

   logic        busy_a, busy_b;
   logic [15:0] fcnt_a;
   logic [1:0]  fcnt_b;

   tdc_fifo_drain_tx #(.DATA_W(DW), .HEADER(8'hA5), .SEND_HEADER(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .busy(busy_a), .frame_cnt(fcnt_a));

   tdc_fifo_drain_tx #(.DATA_W(DW), .HEADER(8'hA5), .SEND_HEADER(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .busy(busy_b), .frame_cnt(fcnt_b));

   // word-level FIFO models with registered read data
   logic [DW-1:0] mem_a [0:63];
   logic [DW-1:0] mem_b [0:63];
   int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

   assign bus_a.buf_empty = (wr_a == rd_a);
   assign bus_b.buf_empty = (wr_b == rd_b);

   always @(posedge clk) begin
      if (bus_a.rd_en && (wr_a != rd_a)) begin
         bus_a.buf_out <= mem_a[rd_a % 64];
         rd_a          <= rd_a + 1;
      end
      if (bus_b.rd_en && (wr_b != rd_b)) begin
         bus_b.buf_out <= mem_b[rd_b % 64];
         rd_b          <= rd_b + 1;
      end
   end

   int n_asrt = 0;
   int n_fail = 0;
   int cyc = 0;
   int ready_mode = 0;

   logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   logic [1:0] fseq_b[$];
   logic [1:0] prev_fcnt_b = '0;
   int   first_a = 0, last_a = 0, pulses_a = 0, pulses_b = 0, last_pulse_a = 0;
   logic prev_rd_a = 1'b0, prev_rd_b = 1'b0;
   logic hold_a = 1'b0, hold_b = 1'b0;
   logic [7:0] hold_data_a = '0, hold_data_b = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic pick_ready();
      case (ready_mode)
         0:       return 1'b1;
         1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // expected frame: optional sync byte, then the word's bytes from the top down
   task automatic push_word(input int sel, input logic [DW-1:0] w);
      if (sel == 0) begin
         mem_a[wr_a % 64] = w;
         wr_a++;
         exp_a.push_back(8'hA5);
         for (int k = 0; k < NB; k++) exp_a.push_back(8'((w >> (8 * (NB - 1 - k))) & 48'hFF));
      end else begin
         mem_b[wr_b % 64] = w;
         wr_b++;
         for (int k = 0; k < NB; k++) exp_b.push_back(8'((w >> (8 * (NB - 1 - k))) & 48'hFF));
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      bus_a.tx_ready = pick_ready();
      bus_b.tx_ready = pick_ready();
      if (hold_a) begin
         check("hold_valid_a", bus_a.tx_valid, 1);
         check("hold_data_a", bus_a.tx_data, hold_data_a);
      end
      if (hold_b) begin
         check("hold_valid_b", bus_b.tx_valid, 1);
         check("hold_data_b", bus_b.tx_data, hold_data_b);
      end
      hold_a      = bus_a.tx_valid && !bus_a.tx_ready;
      hold_data_a = bus_a.tx_data;
      hold_b      = bus_b.tx_valid && !bus_b.tx_ready;
      hold_data_b = bus_b.tx_data;
      if (bus_a.tx_valid && bus_a.tx_ready) begin
         if (got_a.size() == 0) first_a = cyc;
         last_a = cyc;
         got_a.push_back(bus_a.tx_data);
      end
      if (bus_b.tx_valid && bus_b.tx_ready) got_b.push_back(bus_b.tx_data);
      if (bus_a.rd_en) begin
         check("rd_en_single_a", prev_rd_a, 0);
         if (pulses_a > 0) check("pulse_gap_a", (cyc - last_pulse_a) >= 11, 1);
         pulses_a++;
         last_pulse_a = cyc;
      end
      if (bus_b.rd_en) begin
         check("rd_en_single_b", prev_rd_b, 0);
         pulses_b++;
      end
      prev_rd_a = bus_a.rd_en;
      prev_rd_b = bus_b.rd_en;
      if (fcnt_b != prev_fcnt_b) fseq_b.push_back(fcnt_b);
      prev_fcnt_b = fcnt_b;
   endtask

   task automatic wait_idle(input int sel, input int budget);
      int n;
      n = 0;
      repeat (2) step();
      while ((sel == 0 ? (busy_a || wr_a != rd_a) : (busy_b || wr_b != rd_b)) && n < budget) begin
         step();
         n++;
      end
      check(sel == 0 ? "idle_timeout_a" : "idle_timeout_b", n < budget, 1);
   endtask

   task automatic compare(input int sel);
      int ng, ne;
      ng = (sel == 0) ? got_a.size() : got_b.size();
      ne = (sel == 0) ? exp_a.size() : exp_b.size();
      check(sel == 0 ? "byte_count_a" : "byte_count_b", ng, ne);
      for (int i = 0; i < ne && i < ng; i++) begin
         if (sel == 0) check("byte_a", got_a[i], exp_a[i]);
         else          check("byte_b", got_b[i], exp_b[i]);
      end
      if (sel == 0) begin got_a.delete(); exp_a.delete(); end
      else          begin got_b.delete(); exp_b.delete(); end
   endtask

   initial begin
      logic [DW-1:0] w;
      int c0, n;

      bus_a.tx_ready = 1'b0;
      bus_b.tx_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // idle with empty FIFOs
      repeat (20) begin
         step();
         check("idle_rd_en", bus_a.rd_en, 0);
         check("idle_tx_valid", bus_a.tx_valid, 0);
         check("idle_busy", busy_a, 0);
         check("idle_frame_cnt", fcnt_a, 0);
      end

      // single word, sink always ready
      pulses_a = 0;
      push_word(0, 48'h0123_4567_89AB);
      c0 = cyc;
      wait_idle(0, 100);
      check("first_byte_latency", first_a - c0, 3);
      check("burst_length", last_a - first_a, 6);
      compare(0);
      check("pulses_single", pulses_a, 1);
      check("frame_cnt_1", fcnt_a, 1);

      // same word, sink toggling 1,0,0,1
      ready_mode = 1;
      pulses_a = 0;
      push_word(0, 48'h0123_4567_89AB);
      wait_idle(0, 200);
      compare(0);
      check("pulses_toggle", pulses_a, 1);
      check("frame_cnt_2", fcnt_a, 2);

      // three queued random words, sink always ready
      ready_mode = 0;
      pulses_a = 0;
      for (int i = 0; i < 3; i++) begin
         w = DW'({$urandom(), $urandom()});
         push_word(0, w);
      end
      wait_idle(0, 200);
      compare(0);
      check("pulses_three", pulses_a, 3);
      check("frame_cnt_5", fcnt_a, 5);

      // random backpressure
      ready_mode = 2;
      for (int i = 0; i < 4; i++) begin
         w = DW'({$urandom(), $urandom()});
         push_word(0, w);
      end
      wait_idle(0, 400);
      compare(0);
      check("frame_cnt_9", fcnt_a, 9);

      // reset after the third byte of a frame
      ready_mode = 0;
      w = DW'({$urandom(), $urandom()});
      push_word(0, w);
      n = 0;
      while (got_a.size() < 3 && n < 50) begin
         step();
         n++;
      end
      check("mid_frame_reach", got_a.size(), 3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_tx_valid", bus_a.tx_valid, 0);
      check("rst_busy", busy_a, 0);
      check("rst_frame_cnt", fcnt_a, 0);
      check("rst_rd_en", bus_a.rd_en, 0);
      got_a.delete();
      exp_a.delete();
      w = DW'({$urandom(), $urandom()});
      push_word(0, w);
      step();
      hold_a = 1'b0;
      prev_rd_a = 1'b0;
      pulses_a = 0;
      rst_n = 1'b1;
      wait_idle(0, 100);
      check("post_rst_first_sync", got_a.size() > 0 ? got_a[0] : 8'h00, 8'hA5);
      compare(0);
      check("post_rst_frame_cnt", fcnt_a, 1);

      // headerless instance with 2-bit frame counter
      ready_mode = 2;
      fseq_b.delete();
      prev_fcnt_b = fcnt_b;
      pulses_b = 0;
      for (int i = 0; i < 5; i++) begin
         w = DW'({$urandom(), $urandom()});
         push_word(1, w);
      end
      wait_idle(1, 600);
      compare(1);
      check("pulses_b", pulses_b, 5);
      check("fseq_len_b", fseq_b.size(), 5);
      for (int i = 0; i < 5 && i < fseq_b.size(); i++) check("fseq_b", fseq_b[i], (i + 1) % 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
